// File: rtl/ifetch_if.sv
// Fetch-unit bundle: instruction-memory request channel, redirect input and
// decoded-instruction queue head toward the decode stage.
interface ifetch_if;
    logic        oImemReq;
    logic [31:0] oImemAddr;
    logic        iImemAck;
    logic [31:0] iImemRdata;
    logic        iRedirect;
    logic [31:0] iRedirectPc;
    logic        oInstValid;
    logic [31:0] oInst;
    logic [31:0] oInstPc;
    logic        iInstReady;

    modport master (
        output oImemReq, oImemAddr, oInstValid, oInst, oInstPc,
        input  iImemAck, iImemRdata, iRedirect, iRedirectPc, iInstReady
    );

    modport slave (
        input  oImemReq, oImemAddr, oInstValid, oInst, oInstPc,
        output iImemAck, iImemRdata, iRedirect, iRedirectPc, iInstReady
    );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch: one outstanding memory request, small FIFO of fetched
// {instruction, pc} pairs, and redirect handling that discards in-flight data.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic     iClk,
    input  logic     iReset,
    ifetch_if.master bus
);
    localparam int          PW          = $clog2(QDEPTH);
    localparam logic [31:0] RESET_FETCH = {RESET_PC[31:2], 2'b00};
    localparam logic [PW:0] QFULL       = (PW + 1)'(QDEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, KILL} state_t;

    state_t        stateReg, stateNext;
    logic          reqReg, reqNext;
    logic [31:0]   addrReg, addrNext;
    logic [31:0]   fetchPcReg, fetchPcNext;
    logic [PW-1:0] rdPtrReg, wrPtrReg;
    logic [PW:0]   countReg, countNext;
    logic [31:0]   instMem [QDEPTH];
    logic [31:0]   pcMem   [QDEPTH];
    logic          xfer, push, pop, headValid;
    logic [31:0]   redirTarget;

    assign redirTarget = {bus.iRedirectPc[31:2], 2'b00};
    assign headValid   = (countReg != '0);
    assign xfer        = reqReg && bus.iImemAck;
    // Redirect wins over both queue operations in the same cycle.
    assign push        = xfer && (stateReg == BUSY) && !bus.iRedirect;
    assign pop         = headValid && bus.iInstReady && !bus.iRedirect;

    always_comb begin
        countNext = countReg;
        if (bus.iRedirect) begin
            countNext = '0;
        end else begin
            countNext = countReg + (PW + 1)'(push) - (PW + 1)'(pop);
        end
    end

    always_comb begin
        stateNext   = stateReg;
        reqNext     = reqReg;
        addrNext    = addrReg;
        fetchPcNext = fetchPcReg;
        case (stateReg)
            IDLE: begin
                if (bus.iRedirect) begin
                    stateNext   = BUSY;
                    reqNext     = 1'b1;
                    addrNext    = redirTarget;
                    fetchPcNext = redirTarget;
                end else if (countNext < QFULL) begin
                    stateNext = BUSY;
                    reqNext   = 1'b1;
                    addrNext  = fetchPcReg;
                end
            end
            BUSY: begin
                if (xfer) begin
                    if (bus.iRedirect) begin
                        addrNext    = redirTarget;
                        fetchPcNext = redirTarget;
                    end else begin
                        fetchPcNext = fetchPcReg + 32'd4;
                        if (countNext < QFULL) begin
                            addrNext = fetchPcReg + 32'd4;
                        end else begin
                            stateNext = IDLE;
                            reqNext   = 1'b0;
                        end
                    end
                end else if (bus.iRedirect) begin
                    // Request stays on the bus untouched until it completes.
                    stateNext   = KILL;
                    fetchPcNext = redirTarget;
                end
            end
            KILL: begin
                if (bus.iRedirect) begin
                    fetchPcNext = redirTarget;
                end
                if (xfer) begin
                    stateNext = BUSY;
                    addrNext  = bus.iRedirect ? redirTarget : fetchPcReg;
                end
            end
            default: begin
                stateNext = IDLE;
                reqNext   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            stateReg   <= IDLE;
            reqReg     <= 1'b0;
            addrReg    <= '0;
            fetchPcReg <= RESET_FETCH;
            rdPtrReg   <= '0;
            wrPtrReg   <= '0;
            countReg   <= '0;
        end else begin
            stateReg   <= stateNext;
            reqReg     <= reqNext;
            addrReg    <= addrNext;
            fetchPcReg <= fetchPcNext;
            countReg   <= countNext;
            if (bus.iRedirect) begin
                rdPtrReg <= '0;
                wrPtrReg <= '0;
            end else begin
                if (push) wrPtrReg <= wrPtrReg + PW'(1);
                if (pop)  rdPtrReg <= rdPtrReg + PW'(1);
            end
        end
    end

    // Storage needs no reset: the head is masked by the occupancy count.
    always_ff @(posedge iClk) begin
        if (push) begin
            instMem[wrPtrReg] <= bus.iImemRdata;
            pcMem[wrPtrReg]   <= addrReg;
        end
    end

    assign bus.oImemReq   = reqReg;
    assign bus.oImemAddr  = addrReg;
    assign bus.oInstValid = headValid;
    assign bus.oInst      = headValid ? instMem[rdPtrReg] : 32'h0;
    assign bus.oInstPc    = headValid ? pcMem[rdPtrReg] : 32'h0;
endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: per-cycle vector table plus hand-written
// redirect, reset-during-request and PC-wrap sequences.
module tb_ifetch;
    typedef struct {
        bit          rst;
        bit          ack;
        bit          rdy;
        bit          req;
        logic [31:0] addr;
        bit          valid;
        logic [31:0] pc;
    } vec_t;

    logic iClk   = 1'b0;
    logic iReset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs [19];

    always #5 iClk = ~iClk;

    ifetch_if busA();
    ifetch_if busB();

    ifetch #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dutA (
        .iClk  (iClk),
        .iReset(iReset),
        .bus   (busA)
    );

    ifetch #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(2)) dutB (
        .iClk  (iClk),
        .iReset(iReset),
        .bus   (busB)
    );

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Memory model answers with a word derived from the requested address.
    assign busA.iImemRdata = memWord(busA.oImemAddr);
    assign busB.iImemRdata = memWord(busB.oImemAddr);

    function automatic vec_t mkVec(input bit rst, input bit ack, input bit rdy,
                                   input bit req, input logic [31:0] addr,
                                   input bit valid, input logic [31:0] pc);
        vec_t v;
        v.rst   = rst;
        v.ack   = ack;
        v.rdy   = rdy;
        v.req   = req;
        v.addr  = addr;
        v.valid = valid;
        v.pc    = pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic checkA(input string name, input bit req, input logic [31:0] addr,
                          input bit valid, input logic [31:0] pc);
        chk({name, ".req"}, 32'(busA.oImemReq), 32'(req));
        if (req) chk({name, ".addr"}, busA.oImemAddr, addr);
        chk({name, ".valid"}, 32'(busA.oInstValid), 32'(valid));
        chk({name, ".pc"}, busA.oInstPc, valid ? pc : 32'h0);
        chk({name, ".inst"}, busA.oInst, valid ? memWord(pc) : 32'h0);
        $display("%s: req=%0b addr=%h valid=%0b pc=%h inst=%h", name, busA.oImemReq,
                 busA.oImemAddr, busA.oInstValid, busA.oInstPc, busA.oInst);
    endtask

    task automatic checkB(input string name, input logic [31:0] pc);
        chk({name, ".valid"}, 32'(busB.oInstValid), 32'd1);
        chk({name, ".pc"}, busB.oInstPc, pc);
        chk({name, ".inst"}, busB.oInst, memWord(pc));
        $display("%s: valid=%0b pc=%h inst=%h", name, busB.oInstValid, busB.oInstPc, busB.oInst);
    endtask

    task automatic setA(input bit ack, input bit rdy, input bit redir, input logic [31:0] rpc);
        busA.iImemAck    = ack;
        busA.iInstReady  = rdy;
        busA.iRedirect   = redir;
        busA.iRedirectPc = rpc;
    endtask

    task automatic step();
        @(posedge iClk);
        @(negedge iClk);
    endtask

    // Called at a falling edge; returns at the falling edge right after release.
    task automatic doReset();
        iReset = 1'b1;
        setA(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        step();
        chk("reset.req", 32'(busA.oImemReq), 32'd0);
        chk("reset.addr", busA.oImemAddr, 32'h0);
        chk("reset.valid", 32'(busA.oInstValid), 32'd0);
        chk("reset.inst", busA.oInst, 32'h0);
        chk("reset.pc", busA.oInstPc, 32'h0);
        chk("reset.reqB", 32'(busB.oImemReq), 32'd0);
        $display("reset: req=%0b valid=%0b", busA.oImemReq, busA.oInstValid);
        iReset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        setA(1'b0, 1'b0, 1'b0, 32'h0);
        busB.iImemAck    = 1'b1;
        busB.iInstReady  = 1'b1;
        busB.iRedirect   = 1'b0;
        busB.iRedirectPc = 32'h0;

        // Streaming with constant ack, then back-pressure fills the queue.
        vecs[0]  = mkVec(1'b1, 1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00);
        vecs[1]  = mkVec(1'b0, 1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00);
        vecs[2]  = mkVec(1'b0, 1'b1, 1'b1, 1'b1, 32'h04, 1'b1, 32'h00);
        vecs[3]  = mkVec(1'b0, 1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h04);
        vecs[4]  = mkVec(1'b0, 1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h08);
        vecs[5]  = mkVec(1'b0, 1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 32'h0C);
        vecs[6]  = mkVec(1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h0C);
        vecs[7]  = mkVec(1'b0, 1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h0C);
        vecs[8]  = mkVec(1'b0, 1'b0, 1'b0, 1'b1, 32'h14, 1'b1, 32'h10);
        vecs[9]  = mkVec(1'b0, 1'b0, 1'b0, 1'b1, 32'h14, 1'b1, 32'h10);
        // From reset with decode stalled: exactly two entries, then drain.
        vecs[10] = mkVec(1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00);
        vecs[11] = mkVec(1'b0, 1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00);
        vecs[12] = mkVec(1'b0, 1'b1, 1'b0, 1'b1, 32'h04, 1'b1, 32'h00);
        vecs[13] = mkVec(1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h00);
        vecs[14] = mkVec(1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h00);
        vecs[15] = mkVec(1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h00);
        vecs[16] = mkVec(1'b0, 1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h04);
        vecs[17] = mkVec(1'b0, 1'b1, 1'b1, 1'b1, 32'h08, 1'b0, 32'h00);
        vecs[18] = mkVec(1'b0, 1'b0, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h08);

        @(negedge iClk);
        for (int i = 0; i < 19; i++) begin
            if (vecs[i].rst) doReset();
            checkA($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].valid, vecs[i].pc);
            setA(vecs[i].ack, vecs[i].rdy, 1'b0, 32'h0);
            step();
        end

        // Redirect while a request is pending: its data must be discarded.
        doReset();
        checkA("kill.c0", 1'b0, 32'h0, 1'b0, 32'h0);
        setA(1'b0, 1'b1, 1'b1, 32'h10);
        step();
        checkA("kill.c1", 1'b1, 32'h10, 1'b0, 32'h0);
        setA(1'b0, 1'b1, 1'b1, 32'h200);
        step();
        checkA("kill.c2", 1'b1, 32'h10, 1'b0, 32'h0);
        setA(1'b0, 1'b1, 1'b0, 32'h0);
        step();
        checkA("kill.c3", 1'b1, 32'h10, 1'b0, 32'h0);
        setA(1'b1, 1'b1, 1'b0, 32'h0);
        step();
        checkA("kill.c4", 1'b1, 32'h200, 1'b0, 32'h0);
        setA(1'b1, 1'b0, 1'b0, 32'h0);
        step();
        checkA("kill.c5", 1'b1, 32'h204, 1'b1, 32'h200);

        // Unaligned redirect coincident with a transfer and a pop.
        doReset();
        setA(1'b1, 1'b1, 1'b0, 32'h0);
        step();
        checkA("redir.c1", 1'b1, 32'h0, 1'b0, 32'h0);
        step();
        checkA("redir.c2", 1'b1, 32'h4, 1'b1, 32'h0);
        setA(1'b1, 1'b1, 1'b1, 32'h103);
        step();
        checkA("redir.c3", 1'b1, 32'h100, 1'b0, 32'h0);
        setA(1'b1, 1'b1, 1'b0, 32'h0);
        step();
        checkA("redir.c4", 1'b1, 32'h104, 1'b1, 32'h100);

        // Reset lands on the same edge as an acknowledged request.
        doReset();
        setA(1'b0, 1'b1, 1'b0, 32'h0);
        step();
        checkA("rstreq.pre", 1'b1, 32'h0, 1'b0, 32'h0);
        busA.iImemAck = 1'b1;
        #4 iReset = 1'b1;
        @(posedge iClk);
        #1;
        chk("rstreq.req", 32'(busA.oImemReq), 32'd0);
        chk("rstreq.valid", 32'(busA.oInstValid), 32'd0);
        $display("rstreq.edge: req=%0b valid=%0b", busA.oImemReq, busA.oInstValid);
        @(negedge iClk);
        busA.iImemAck = 1'b0;
        iReset = 1'b0;
        checkA("rstreq.c0", 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        checkA("rstreq.c1", 1'b1, 32'h0, 1'b0, 32'h0);
        step();
        checkA("rstreq.c2", 1'b1, 32'h0, 1'b0, 32'h0);

        // Fetch PC wraps past the top of the address space.
        doReset();
        step();
        step();
        checkB("wrap.c2", 32'hFFFF_FFF8);
        step();
        checkB("wrap.c3", 32'hFFFF_FFFC);
        step();
        checkB("wrap.c4", 32'h0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
